// File: rtl/aes_job_ctrl.sv
// aes_job_ctrl
// Job sequencer for the shared-S-box AES-256 core. It accepts a descriptor from
// the host and resets the core. It then loads 32 key bytes, either streamed from
// the host or replayed from the local key cache, followed by 16 state bytes. It
// starts the core, captures the ciphertext and streams it back out MSB-first.
// This block is the only master of the core's load and start pins.
//
// Build option: AES_CTRL_KEY_CACHE_EN
//   defined   - 256-bit key cache; nk=0 jobs replay the last streamed key
//   undefined - no cache storage; every nk=0 descriptor is rejected with err
//
// Ports
//   clk, rst_n                             clock, synchronous active-low reset
//   job_valid, job_new_key, job_ready      descriptor handshake
//   in_valid, in_byte, in_ready            host byte stream (key bytes, then block bytes)
//   out_valid, out_byte, out_last, out_ready  ciphertext byte stream
//   busy, err                              status; err is a one-cycle reject pulse
//   core_rst_n                             registered reset to the core
//   core_key_valid/byte/ready              core key load handshake
//   core_state_valid/byte/ready            core state load handshake
//   core_start, core_done, core_state_out  core run control and result
//
// state | meaning
// IDLE  | waiting for a descriptor; nk=0 without a cached key is rejected here
// CRST  | core reset held low for one cycle
// KEY   | 32 key byte transfers (host pass-through or cache replay)
// BLK   | 16 state byte transfers from the host
// GO    | wait for the core to report full, then pulse start
// RUN   | wait for core_done, capture the ciphertext
// OUT   | stream 16 ciphertext bytes
module aes_job_ctrl (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         job_valid,
   input  logic         job_new_key,
   output logic         job_ready,
   input  logic         in_valid,
   input  logic [7:0]   in_byte,
   output logic         in_ready,
   output logic         out_valid,
   output logic [7:0]   out_byte,
   output logic         out_last,
   input  logic         out_ready,
   output logic         busy,
   output logic         err,
   output logic         core_rst_n,
   output logic         core_key_valid,
   output logic [7:0]   core_key_byte,
   input  logic         core_key_ready,
   output logic         core_state_valid,
   output logic [7:0]   core_state_byte,
   input  logic         core_state_ready,
   output logic         core_start,
   input  logic         core_done,
   input  logic [127:0] core_state_out
);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      CRST = 3'd1,
      KEY  = 3'd2,
      BLK  = 3'd3,
      GO   = 3'd4,
      RUN  = 3'd5,
      OUT  = 3'd6
   } state_t;

   state_t         state, state_nxt;
   logic           nk, nk_nxt;
   logic [4:0]     kc, kc_nxt;
   logic [3:0]     bc, bc_nxt;
   logic [3:0]     oc, oc_nxt;
   logic [127:0]   obuf, obuf_nxt;
   logic           err_nxt;
   logic           start_nxt;
   logic           key_xfer;
   logic           key_avail;
   logic [7:0]     replay_byte;

`ifdef AES_CTRL_KEY_CACHE_EN
   logic [7:0]     cache_mem [32];
   logic           cache_vld;
   logic           cache_wr;

   assign key_avail   = cache_vld;
   assign replay_byte = cache_mem[kc];
   assign cache_wr    = (state == KEY) && nk && key_xfer;

   // Storage only; validity is tracked separately so the array needs no reset.
   always_ff @(posedge clk) begin
      if (rst_n && cache_wr) begin
         cache_mem[kc] <= in_byte;
      end
   end

   // The key becomes usable only once all 32 bytes have been streamed.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cache_vld <= 1'b0;
      end else if (cache_wr && (kc == 5'd31)) begin
         cache_vld <= 1'b1;
      end
   end
`else
   assign key_avail   = 1'b0;
   assign replay_byte = 8'h00;
`endif

   // The ciphertext is shifted out of the top byte, so the byte on the bus is
   // always a flop output and obuf drains back to zero after the last byte.
   assign out_byte = obuf[127:120];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         nk         <= 1'b0;
         kc         <= 5'd0;
         bc         <= 4'd0;
         oc         <= 4'd0;
         obuf       <= 128'd0;
         job_ready  <= 1'b0;
         busy       <= 1'b0;
         err        <= 1'b0;
         core_rst_n <= 1'b0;
         core_start <= 1'b0;
         out_valid  <= 1'b0;
         out_last   <= 1'b0;
      end else begin
         state      <= state_nxt;
         nk         <= nk_nxt;
         kc         <= kc_nxt;
         bc         <= bc_nxt;
         oc         <= oc_nxt;
         obuf       <= obuf_nxt;
         job_ready  <= (state_nxt == IDLE);
         busy       <= (state_nxt != IDLE);
         err        <= err_nxt;
         core_rst_n <= (state_nxt != CRST);
         core_start <= start_nxt;
         out_valid  <= (state_nxt == OUT);
         out_last   <= (state_nxt == OUT) && (oc_nxt == 4'd15);
      end
   end

   always_comb begin
      state_nxt        = state;
      nk_nxt           = nk;
      kc_nxt           = kc;
      bc_nxt           = bc;
      oc_nxt           = oc;
      obuf_nxt         = obuf;
      err_nxt          = 1'b0;
      start_nxt        = 1'b0;
      key_xfer         = 1'b0;
      in_ready         = 1'b0;
      core_key_valid   = 1'b0;
      core_key_byte    = 8'h00;
      core_state_valid = 1'b0;
      core_state_byte  = 8'h00;

      case (state)
         IDLE: begin
            if (job_valid && job_ready) begin
               nk_nxt = job_new_key;
               if (!job_new_key && !key_avail) begin
                  err_nxt = 1'b1;
               end else begin
                  state_nxt = CRST;
               end
            end
         end

         CRST: begin
            kc_nxt    = 5'd0;
            state_nxt = KEY;
         end

         KEY: begin
            if (nk) begin
               core_key_valid = in_valid;
               core_key_byte  = in_byte;
               in_ready       = core_key_ready;
            end else begin
               core_key_valid = 1'b1;
               core_key_byte  = replay_byte;
            end
            key_xfer = core_key_valid && core_key_ready;
            if (key_xfer) begin
               kc_nxt = kc + 5'd1;
               if (kc == 5'd31) begin
                  bc_nxt    = 4'd0;
                  state_nxt = BLK;
               end
            end
         end

         BLK: begin
            core_state_valid = in_valid;
            core_state_byte  = in_byte;
            in_ready         = core_state_ready;
            if (in_valid && core_state_ready) begin
               bc_nxt = bc + 4'd1;
               if (bc == 4'd15) begin
                  state_nxt = GO;
               end
            end
         end

         // The core drops both readies only once key and state are full.
         GO: begin
            if (!core_key_ready && !core_state_ready) begin
               start_nxt = 1'b1;
               state_nxt = RUN;
            end
         end

         RUN: begin
            if (core_done) begin
               obuf_nxt  = core_state_out;
               oc_nxt    = 4'd0;
               state_nxt = OUT;
            end
         end

         OUT: begin
            if (out_valid && out_ready) begin
               obuf_nxt = {obuf[119:0], 8'h00};
               oc_nxt   = oc + 4'd1;
               if (oc == 4'd15) begin
                  state_nxt = IDLE;
               end
            end
         end

         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

endmodule
